// File: rtl/elastic_skid_fifo.sv
// elastic_skid_fifo: DEPTH-entry valid/ready elastic buffer with either a
// zero-latency bypass when empty (REG_OUT=0) or a fully registered output (REG_OUT=1).
module elastic_skid_fifo #(
   parameter int DWIDTH    = 8,
   parameter int DEPTH     = 4,
   parameter int REG_OUT   = 0,
   parameter int AF_THRESH = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic [DWIDTH-1:0]          i_data,
   input  logic                       i_valid,
   output logic                       o_ready,
   output logic [DWIDTH-1:0]          o_data,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_empty,
   output logic                       o_full,
   output logic                       o_almost_full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

   logic [DWIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic              empty_s;
   logic              full_s;
   logic              bypass_s;
   logic              push_s;
   logic              pop_s;

   // Status decode, output mux and transfer qualification from registered state.
   always_comb begin
      empty_s       = (count_r == {CW{1'b0}});
      full_s        = (count_r == DEPTH_C);
      o_count       = count_r;
      o_empty       = empty_s;
      o_full        = full_s;
      o_almost_full = (count_r >= AF_C);
      o_ready       = !full_s;
      if ((REG_OUT == 0) && empty_s) begin
         o_valid = i_valid;
         o_data  = i_data;
      end else begin
         o_valid = !empty_s;
         o_data  = mem_r[rd_ptr_r];
      end
      // A word only bypasses storage when nothing older is waiting ahead of it.
      bypass_s = (REG_OUT == 0) && empty_s && i_valid && i_ready;
      push_s   = i_valid && !full_s && !bypass_s;
      pop_s    = !empty_s && i_ready;
   end

   // Storage, pointers and occupancy; flush outranks any same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DWIDTH{1'b0}};
         end
      end else if (i_flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= i_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
   end
endmodule

// File: tb/tb_elastic_skid_fifo.sv
// Bench for elastic_skid_fifo: three configurations share one stimulus stream,
// directed scenarios plus a randomized run against a queue-based reference model.
module tb_elastic_skid_fifo;
   logic       clk = 1'b0;
   logic       rst, flush, vin, rin;
   logic [7:0] din;
   logic [7:0] od   [3];
   logic       ov   [3];
   logic       ordy [3];
   logic       emp  [3];
   logic       ful  [3];
   logic       af   [3];
   logic [2:0] cnt  [3];
   logic [2:0] cnt_a, cnt_c;
   logic [1:0] cnt_b;
   int         n_chk = 0;
   int         n_pass = 0;

   // Reference model: per-instance array of stored words, oldest at index 0.
   logic [7:0] mq  [3][8];
   int         mc  [3] = '{0, 0, 0};
   int         md  [3] = '{4, 2, 4};
   int         mr  [3] = '{0, 1, 1};
   int         maf [3] = '{3, 1, 3};

   assign cnt[0] = cnt_a;
   assign cnt[1] = {1'b0, cnt_b};
   assign cnt[2] = cnt_c;

   always #5 clk = ~clk;

   elastic_skid_fifo #(.DWIDTH(8), .DEPTH(4), .REG_OUT(0)) u_a (
      .clk(clk), .rst(rst), .i_flush(flush), .i_data(din), .i_valid(vin), .o_ready(ordy[0]),
      .o_data(od[0]), .o_valid(ov[0]), .i_ready(rin), .o_count(cnt_a), .o_empty(emp[0]),
      .o_full(ful[0]), .o_almost_full(af[0]));
   elastic_skid_fifo #(.DWIDTH(8), .DEPTH(2), .REG_OUT(1)) u_b (
      .clk(clk), .rst(rst), .i_flush(flush), .i_data(din), .i_valid(vin), .o_ready(ordy[1]),
      .o_data(od[1]), .o_valid(ov[1]), .i_ready(rin), .o_count(cnt_b), .o_empty(emp[1]),
      .o_full(ful[1]), .o_almost_full(af[1]));
   elastic_skid_fifo #(.DWIDTH(8), .DEPTH(4), .REG_OUT(1)) u_c (
      .clk(clk), .rst(rst), .i_flush(flush), .i_data(din), .i_valid(vin), .o_ready(ordy[2]),
      .o_data(od[2]), .o_valid(ov[2]), .i_ready(rin), .o_count(cnt_c), .o_empty(emp[2]),
      .o_full(ful[2]), .o_almost_full(af[2]));

   function automatic logic exp_valid(int k);
      if (mr[k] == 0 && mc[k] == 0) return vin;
      return mc[k] != 0;
   endfunction

   function automatic logic [7:0] exp_data(int k);
      if (mr[k] == 0 && mc[k] == 0) return din;
      return mq[k][0];
   endfunction

   task automatic model_update();
      for (int k = 0; k < 3; k++) begin
         logic pop, acc;
         pop = exp_valid(k) & rin;
         acc = vin & (mc[k] < md[k]);
         if (rst || flush) begin
            mc[k] = 0;
         end else if (!(mr[k] == 0 && mc[k] == 0 && acc && rin)) begin
            if (pop) begin
               for (int j = 0; j < 7; j++) mq[k][j] = mq[k][j+1];
               mc[k]--;
            end
            if (acc) begin
               mq[k][mc[k]] = din;
               mc[k]++;
            end
         end
      end
   endtask

   task automatic drive(logic r, logic f, logic v, logic [7:0] d, logic rd);
      rst = r; flush = f; vin = v; din = d; rin = rd;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step();
      step();
      drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0);
      n_chk++; if (ordy[0] !== 1'b1 || ordy[2] !== 1'b1)
         $display("FAIL reset_ready_during: got %b/%b want 1/1", ordy[0], ordy[2]); else n_pass++;
      n_chk++; if (ov[0] !== 1'b1 || od[0] !== 8'h5A)
         $display("FAIL reset_bypass: got v=%b d=%h want v=1 d=5a", ov[0], od[0]); else n_pass++;
      step();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) begin
         n_chk++; if ({cnt[k], emp[k], ful[k], af[k], ordy[k]} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_flags[%0d]: got cnt=%0d e=%b f=%b af=%b r=%b want 0 1 0 0 1",
                     k, cnt[k], emp[k], ful[k], af[k], ordy[k]); else n_pass++;
         n_chk++; if (ov[k] !== 1'b0)
            $display("FAIL reset_valid[%0d]: got %b want 0", k, ov[k]); else n_pass++;
      end
   endtask

   task automatic test_bypass();
      logic [7:0] w [3];
      w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, w[i], 1'b1);
         n_chk++; if (ov[0] !== 1'b1 || od[0] !== w[i] || cnt[0] !== 3'd0 || ordy[0] !== 1'b1)
            $display("FAIL bypass_%0d: got v=%b d=%h cnt=%0d r=%b want 1 %h 0 1",
                     i, ov[0], od[0], cnt[0], ordy[0], w[i]); else n_pass++;
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      step();
   endtask

   task automatic test_skid();
      logic acc;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
         step();
         n_chk++; if (cnt[0] !== 3'(i + 1) || af[0] !== (i >= 2) || ful[0] !== (i == 3))
            $display("FAIL skid_fill_%0d: got cnt=%0d af=%b f=%b want %0d %b %b",
                     i, cnt[0], af[0], ful[0], i + 1, (i >= 2), (i == 3)); else n_pass++;
      end
      drive(1'b0, 1'b0, 1'b1, 8'hA4, 1'b0);
      n_chk++; if (ordy[0] !== 1'b0 || ov[0] !== 1'b1 || od[0] !== 8'hA0)
         $display("FAIL skid_full: got r=%b v=%b d=%h want 0 1 a0", ordy[0], ov[0], od[0]); else n_pass++;
      step();
      n_chk++; if (cnt[0] !== 3'd4)
         $display("FAIL skid_hold: got cnt=%0d want 4", cnt[0]); else n_pass++;
      drive(1'b0, 1'b0, 1'b1, 8'hA4, 1'b1);
      for (int k = 0; k < 5; k++) begin
         n_chk++; if (ov[0] !== 1'b1 || od[0] !== 8'hA0 + 8'(k))
            $display("FAIL skid_drain_%0d: got v=%b d=%h want 1 %h", k, ov[0], od[0], 8'hA0 + 8'(k));
         else n_pass++;
         acc = vin & ordy[0];
         step();
         drive(1'b0, 1'b0, vin & !acc, din, 1'b1);
      end
      n_chk++; if (cnt[0] !== 3'd0 || emp[0] !== 1'b1)
         $display("FAIL skid_empty: got cnt=%0d e=%b want 0 1", cnt[0], emp[0]); else n_pass++;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      repeat (4) step();
   endtask

   task automatic test_registered();
      for (int c = 0; c < 9; c++) begin
         drive(1'b0, 1'b0, c < 8, 8'(c + 1), 1'b1);
         n_chk++; if (cnt[1] > 3'd1 || ordy[1] !== 1'b1)
            $display("FAIL reg_count_%0d: got cnt=%0d r=%b want <=1 1", c, cnt[1], ordy[1]); else n_pass++;
         if (c == 0) begin
            n_chk++; if (ov[1] !== 1'b0)
               $display("FAIL reg_first_latency: got v=%b want 0", ov[1]); else n_pass++;
         end else begin
            n_chk++; if (ov[1] !== 1'b1 || od[1] !== 8'(c))
               $display("FAIL reg_word_%0d: got v=%b d=%h want 1 %h", c, ov[1], od[1], 8'(c)); else n_pass++;
         end
         step();
      end
   endtask

   task automatic test_wrap();
      logic [7:0] got_q [$];
      int sent = 0;
      int cyc = 0;
      logic acc;
      void'($urandom(1));
      while (got_q.size() < 6 && cyc < 200) begin
         drive(1'b0, 1'b0, sent < 6, 8'hC0 + 8'(sent), 1'($urandom_range(0, 1)));
         acc = vin & ordy[0];
         if (ov[0] && rin) got_q.push_back(od[0]);
         step();
         if (acc) sent++;
         cyc++;
      end
      n_chk++; if (got_q.size() != 6)
         $display("FAIL wrap_count: got %0d words want 6", got_q.size()); else n_pass++;
      for (int i = 0; i < got_q.size(); i++) begin
         n_chk++; if (got_q[i] !== 8'hC0 + 8'(i))
            $display("FAIL wrap_order_%0d: got %h want %h", i, got_q[i], 8'hC0 + 8'(i)); else n_pass++;
      end
   endtask

   task automatic test_flush();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      repeat (3) step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'h10 + 8'(i), 1'b0);
         step();
      end
      drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
      n_chk++; if (cnt[0] !== 3'd3 || ordy[0] !== 1'b1 || ordy[1] !== 1'b0 || od[0] !== 8'h10)
         $display("FAIL flush_cycle: got cnt=%0d rA=%b rB=%b d=%h want 3 1 0 10",
                  cnt[0], ordy[0], ordy[1], od[0]); else n_pass++;
      step();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) begin
         n_chk++; if (cnt[k] !== 3'd0 || emp[k] !== 1'b1 || ordy[k] !== 1'b1 || ov[k] !== 1'b0)
            $display("FAIL flush_after[%0d]: got cnt=%0d e=%b r=%b v=%b want 0 1 1 0",
                     k, cnt[k], emp[k], ordy[k], ov[k]); else n_pass++;
      end
      drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
      n_chk++; if (ov[0] !== 1'b1 || od[0] !== 8'h55)
         $display("FAIL flush_bypass: got v=%b d=%h want 1 55", ov[0], od[0]); else n_pass++;
      step();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      n_chk++; if (cnt[0] !== 3'd0 || cnt[2] !== 3'd0)
         $display("FAIL flush_bypass_count: got %0d/%0d want 0/0", cnt[0], cnt[2]); else n_pass++;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'h30 + 8'(i), 1'b0);
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      n_chk++; if (cnt[2] !== 3'd3)
         $display("FAIL rstmid_fill: got cnt=%0d want 3", cnt[2]); else n_pass++;
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      n_chk++; if (cnt[2] !== 3'd0 || emp[2] !== 1'b1 || ordy[2] !== 1'b1 || ov[2] !== 1'b0)
         $display("FAIL rstmid_state: got cnt=%0d e=%b r=%b v=%b want 0 1 1 0",
                  cnt[2], emp[2], ordy[2], ov[2]); else n_pass++;
      drive(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
      step();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      n_chk++; if (ov[2] !== 1'b1 || od[2] !== 8'h77)
         $display("FAIL rstmid_first: got v=%b d=%h want 1 77", ov[2], od[2]); else n_pass++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
               8'($urandom), $urandom_range(0, 3) != 0);
         for (int k = 0; k < 3; k++) begin
            n_chk++; if (ov[k] !== exp_valid(k) || ordy[k] !== (mc[k] < md[k]))
               $display("FAIL rnd_handshake[%0d] cyc %0d: got v=%b r=%b want %b %b",
                        k, c, ov[k], ordy[k], exp_valid(k), (mc[k] < md[k])); else n_pass++;
            if (exp_valid(k)) begin
               n_chk++; if (od[k] !== exp_data(k))
                  $display("FAIL rnd_data[%0d] cyc %0d: got %h want %h", k, c, od[k], exp_data(k));
               else n_pass++;
            end
            n_chk++; if (cnt[k] !== 3'(mc[k]) || emp[k] !== (mc[k] == 0) || ful[k] !== (mc[k] == md[k])
                         || af[k] !== (mc[k] >= maf[k]))
               $display("FAIL rnd_status[%0d] cyc %0d: got cnt=%0d e=%b f=%b af=%b want cnt=%0d",
                        k, c, cnt[k], emp[k], ful[k], af[k], mc[k]); else n_pass++;
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_skid();
      test_registered();
      test_wrap();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
